// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - register map and status/control bit positions shared by I/O-space ports
package io_port_pkg;

  localparam logic [15:0] OFS_DATA = 16'd0;
  localparam logic [15:0] OFS_STAT = 16'd1;

  localparam int ST_FULL  = 7;
  localparam int ST_EMPTY = 6;
  localparam int ST_OVF   = 5;

  localparam int CT_FLUSH  = 0;
  localparam int CT_CLROVF = 1;

  function automatic logic [7:0] make_status(input logic full, input logic empty,
                                             input logic ovf, input logic [3:0] cnt);
    logic [7:0] s;
    s = {4'b0000, cnt};
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/io_tx_port_if.sv
// rtl/io_tx_port_if.sv - byte stream from the transmit FIFO head to its consumer
interface io_tx_port_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/io_tx_port_fifo.sv
// rtl/io_tx_port_fifo.sv - power-of-two synchronous FIFO with flush; full rejects push even alongside a pop
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign head    = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/io_tx_port.sv
// rtl/io_tx_port.sv - I/O-space transmit port: data register feeds a FIFO drained over a valid/ready stream
module io_tx_port
  import io_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          DEPTH     = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         ior_,
  input  logic         iow_,
  input  logic [15:0]  a15_a0,
  inout  wire  [7:0]   d7_d0,
  io_tx_port_if.master tx
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          r_iow_q;
  logic          r_ior_q;
  logic          r_ovf;
  logic          w_sel_d;
  logic          w_sel_s;
  logic          w_wr_evt;
  logic          w_rd_evt;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;
  logic [7:0]    w_status;
  logic [7:0]    w_rdata;
  logic          w_oe;

  assign w_sel_d  = (a15_a0 == BASE_ADDR + OFS_DATA);
  assign w_sel_s  = (a15_a0 == BASE_ADDR + OFS_STAT);
  assign w_wr_evt = !iow_ && r_iow_q;
  assign w_rd_evt = !ior_ && r_ior_q;

  assign w_push  = w_wr_evt && w_sel_d && !w_full;
  assign w_flush = w_wr_evt && w_sel_s && d7_d0[CT_FLUSH];
  assign w_pop   = tx.tx_valid && tx.tx_ready;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_iow_q <= 1'b1;
      r_ior_q <= 1'b1;
    end else begin
      r_iow_q <= iow_;
      r_ior_q <= ior_;
    end
  end

  // A write strobe wins over a coincident read, so the read never clears ovf then.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_ovf <= 1'b0;
    end else if (w_wr_evt && w_sel_d && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_wr_evt && w_sel_s && d7_d0[CT_CLROVF]) begin
      r_ovf <= 1'b0;
    end else if (w_rd_evt && !w_wr_evt && w_sel_s) begin
      r_ovf <= 1'b0;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock  (clock),
    .reset_ (reset_),
    .push   (w_push),
    .pop    (w_pop),
    .flush  (w_flush),
    .din    (d7_d0),
    .head   (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign tx.tx_data  = w_head;
  assign tx.tx_valid = !w_empty;

  assign w_status = make_status(w_full, w_empty, r_ovf, 4'(w_count));
  assign w_rdata  = w_sel_s ? w_status : (w_empty ? 8'h00 : w_head);
  assign w_oe     = reset_ && !ior_ && (w_sel_s || w_sel_d);
  assign d7_d0    = w_oe ? w_rdata : 8'hzz;

endmodule

// File: tb/tb_io_tx_port.sv
// tb/tb_io_tx_port.sv - directed vectors and corner sequences for io_tx_port
module tb_io_tx_port;

  logic        clock = 1'b0;
  logic        reset_;
  logic        ior_;
  logic        iow_;
  logic [15:0] a15_a0;
  logic        tb_oe;
  logic [7:0]  tb_d;
  tri1  [7:0]  d7_d0;

  io_tx_port_if txi ();

  assign d7_d0 = tb_oe ? tb_d : 8'hzz;

  io_tx_port #(
    .BASE_ADDR (16'h0100),
    .DEPTH     (4)
  ) dut (
    .clock  (clock),
    .reset_ (reset_),
    .ior_   (ior_),
    .iow_   (iow_),
    .a15_a0 (a15_a0),
    .d7_d0  (d7_d0),
    .tx     (txi)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          hold;
    logic [7:0]  exp_rd;
    logic        exp_valid;
    logic        chk_data;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [22];
  logic [7:0] q [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data, input int hold);
    a15_a0 = addr;
    tb_d   = data;
    tb_oe  = 1'b1;
    iow_   = 1'b0;
    repeat (hold) begin
      @(posedge clock); #1;
    end
    iow_  = 1'b1;
    tb_oe = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [7:0] val);
    a15_a0 = addr;
    ior_   = 1'b0;
    #1;
    val = d7_d0;
    @(posedge clock); #1;
    ior_ = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [7:0] rd;

    //           wr    addr      data  hold exp_rd  valid chk  exp_data
    vecs[0]  = '{1'b0, 16'h0101, 8'h00, 1, 8'h40, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 16'h0100, 8'h00, 1, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 16'h0100, 8'hA5, 3, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 16'h0101, 8'h00, 1, 8'h01, 1'b1, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 16'h0100, 8'h00, 1, 8'hA5, 1'b1, 1'b1, 8'hA5};
    vecs[5]  = '{1'b1, 16'h0102, 8'h77, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[6]  = '{1'b1, 16'h00FF, 8'h77, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[7]  = '{1'b0, 16'h0101, 8'h00, 1, 8'h01, 1'b1, 1'b1, 8'hA5};
    vecs[8]  = '{1'b0, 16'h0102, 8'h00, 1, 8'hFF, 1'b1, 1'b1, 8'hA5};
    vecs[9]  = '{1'b1, 16'h0100, 8'hB6, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[10] = '{1'b1, 16'h0100, 8'hC7, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[11] = '{1'b1, 16'h0100, 8'hD8, 2, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[12] = '{1'b0, 16'h0101, 8'h00, 1, 8'h84, 1'b1, 1'b1, 8'hA5};
    vecs[13] = '{1'b1, 16'h0100, 8'hE9, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[14] = '{1'b0, 16'h0101, 8'h00, 1, 8'hA4, 1'b1, 1'b1, 8'hA5};
    vecs[15] = '{1'b0, 16'h0101, 8'h00, 1, 8'h84, 1'b1, 1'b1, 8'hA5};
    vecs[16] = '{1'b1, 16'h0100, 8'hF0, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[17] = '{1'b1, 16'h0101, 8'h02, 1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[18] = '{1'b0, 16'h0101, 8'h00, 1, 8'h84, 1'b1, 1'b1, 8'hA5};
    vecs[19] = '{1'b1, 16'h0101, 8'h01, 1, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[20] = '{1'b0, 16'h0101, 8'h00, 1, 8'h40, 1'b0, 1'b0, 8'h00};
    vecs[21] = '{1'b0, 16'h0100, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h00};

    reset_ = 1'b0;
    ior_   = 1'b1;
    iow_   = 1'b1;
    a15_a0 = 16'h0000;
    tb_oe  = 1'b0;
    tb_d   = 8'h00;
    txi.tx_ready = 1'b0;

    #12;
    chk("reset_bus_hiz", d7_d0, 8'hFF);
    chk("reset_valid", {7'b0, txi.tx_valid}, 8'h00);
    #10 reset_ = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].wr) begin
        bus_wr(vecs[i].addr, vecs[i].data, vecs[i].hold);
      end else begin
        bus_rd(vecs[i].addr, rd);
        chk($sformatf("vec%0d_read", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_valid", i), {7'b0, txi.tx_valid}, {7'b0, vecs[i].exp_valid});
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), txi.tx_data, vecs[i].exp_data);
    end

    // Overfill then drain one per clock.
    for (int i = 1; i <= 5; i++) bus_wr(16'h0100, 8'(i), 1);
    bus_rd(16'h0101, rd);
    chk("ovf_status_first", rd, 8'hA4);
    bus_rd(16'h0101, rd);
    chk("ovf_status_second", rd, 8'h84);
    txi.tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_valid", i), {7'b0, txi.tx_valid}, 8'h01);
      chk($sformatf("drain%0d_data", i), txi.tx_data, 8'(i));
      @(posedge clock); #1;
    end
    chk("drain_empty_valid", {7'b0, txi.tx_valid}, 8'h00);
    txi.tx_ready = 1'b0;

    // Push latency and a long strobe giving a single entry.
    a15_a0 = 16'h0100;
    tb_d   = 8'h3C;
    tb_oe  = 1'b1;
    iow_   = 1'b0;
    #1;
    chk("lat_before_edge_valid", {7'b0, txi.tx_valid}, 8'h00);
    @(posedge clock); #1;
    chk("lat_after_edge_valid", {7'b0, txi.tx_valid}, 8'h01);
    chk("lat_after_edge_data", txi.tx_data, 8'h3C);
    repeat (2) begin
      @(posedge clock); #1;
    end
    iow_  = 1'b1;
    tb_oe = 1'b0;
    @(posedge clock); #1;
    bus_rd(16'h0101, rd);
    chk("lat_single_push", rd, 8'h01);
    bus_wr(16'h0101, 8'h01, 1);

    // Push and pop on the same edge across pointer wrap-around.
    bus_wr(16'h0100, 8'h10, 1);
    bus_wr(16'h0100, 8'h11, 1);
    q = {8'h10, 8'h11};
    for (int k = 0; k < 10; k++) begin
      a15_a0 = 16'h0100;
      tb_d   = 8'h20 + 8'(k);
      tb_oe  = 1'b1;
      iow_   = 1'b0;
      txi.tx_ready = 1'b1;
      #1;
      chk($sformatf("wrap%0d_head", k), txi.tx_data, q[0]);
      @(posedge clock); #1;
      void'(q.pop_front());
      q.push_back(8'h20 + 8'(k));
      iow_  = 1'b1;
      tb_oe = 1'b0;
      txi.tx_ready = 1'b0;
      @(posedge clock); #1;
    end
    bus_rd(16'h0101, rd);
    chk("wrap_count", rd, 8'h02);
    chk("wrap_head_final", txi.tx_data, q[0]);

    // Flush racing a pop.
    bus_wr(16'h0100, 8'h66, 1);
    bus_rd(16'h0101, rd);
    chk("pre_flush_count", rd, 8'h03);
    txi.tx_ready = 1'b1;
    bus_wr(16'h0101, 8'h01, 1);
    txi.tx_ready = 1'b0;
    chk("flush_valid", {7'b0, txi.tx_valid}, 8'h00);
    bus_rd(16'h0101, rd);
    chk("flush_status", rd, 8'h40);

    // Reset during an active status read.
    bus_wr(16'h0100, 8'h5A, 1);
    a15_a0 = 16'h0101;
    ior_   = 1'b0;
    #1;
    chk("mid_read_bus", d7_d0, 8'h01);
    reset_ = 1'b0;
    #1;
    chk("reset_mid_read_hiz", d7_d0, 8'hFF);
    chk("reset_mid_valid", {7'b0, txi.tx_valid}, 8'h00);
    chk("reset_mid_data", txi.tx_data, 8'h00);
    ior_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b1;
    @(posedge clock); #1;
    bus_rd(16'h0101, rd);
    chk("post_reset_status", rd, 8'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
